piano_voice_scheduler: RTL

PIANO_VOICE_SCHEDULER -- requirements
Module: piano_voice_scheduler

---
 rtl/piano_voice_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/piano_voice_scheduler.sv
`default_nettype none
// ============================================================================
// piano_voice_scheduler
// Scans key switches one per cycle, allocating up to NVOICE voices with
// oldest-voice stealing.
// Revision: 1.0
// ============================================================================
module piano_voice_scheduler #(
  parameter int NKEYS  = 36,
  parameter int NVOICE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NKEYS-1:0]      switches,
  output logic [NKEYS-1:0]      key_mask,
  output logic [NVOICE-1:0]     voice_valid,
  output logic [NVOICE*6-1:0]   voice_key,
  output logic                  scan_done
);

  localparam int         VW     = (NVOICE > 1) ? $clog2(NVOICE) : 1;
  localparam logic [5:0] C_LAST = 6'(NKEYS - 1);

  logic [NKEYS-1:0]  r_sync1;
  logic [NKEYS-1:0]  r_sync2;
  logic [5:0]        r_ptr;
  logic              r_scan_done;
  logic [NKEYS-1:0]  r_owned;
  logic [NKEYS-1:0]  r_blocked;
  logic [NVOICE-1:0] r_valid;
  logic [5:0]        r_key [NVOICE];
  logic [7:0]        r_age [NVOICE];

  logic          w_sw;
  logic          w_press;
  logic          w_release;
  logic          w_has_free;
  logic [VW-1:0] w_free_idx;
  logic [VW-1:0] w_old_idx;
  logic [VW-1:0] w_rel_idx;
  logic [7:0]    w_best_age;

  assign w_sw      = r_sync2[r_ptr];
  assign w_press   = w_sw && !r_owned[r_ptr] && !r_blocked[r_ptr];
  assign w_release = !w_sw && r_owned[r_ptr];

  // Voice selection: lowest free voice, oldest voice (ties to lowest index),
  // and the voice owned by the key currently under the pointer.
  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    w_rel_idx  = '0;
    w_old_idx  = '0;
    w_best_age = r_age[0];
    for (int v = NVOICE - 1; v >= 0; v--) begin
      if (!r_valid[v]) begin
        w_has_free = 1'b1;
        w_free_idx = VW'(v);
      end
    end
    for (int v = 1; v < NVOICE; v++) begin
      if (r_age[v] > w_best_age) begin
        w_best_age = r_age[v];
        w_old_idx  = VW'(v);
      end
    end
    for (int v = 0; v < NVOICE; v++) begin
      if (r_valid[v] && (r_key[v] == r_ptr)) begin
        w_rel_idx = VW'(v);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_ptr       <= '0;
      r_scan_done <= 1'b0;
      r_owned     <= '0;
      r_blocked   <= '0;
      r_valid     <= '0;
      for (int v = 0; v < NVOICE; v++) begin
        r_key[v] <= '0;
        r_age[v] <= '0;
      end
    end else begin
      r_sync1     <= switches;
      r_sync2     <= r_sync1;
      r_ptr       <= (r_ptr == C_LAST) ? 6'd0 : r_ptr + 6'd1;
      r_scan_done <= (r_ptr == C_LAST);

      for (int v = 0; v < NVOICE; v++) begin
        if (!r_valid[v]) begin
          r_age[v] <= '0;
        end else if (r_scan_done && (r_age[v] != 8'hFF)) begin
          r_age[v] <= r_age[v] + 8'd1;
        end
      end

      if (!w_sw) begin
        r_blocked[r_ptr] <= 1'b0;
      end

      // Later assignments to the same voice override the age update above.
      if (w_press) begin
        r_owned[r_ptr] <= 1'b1;
        if (w_has_free) begin
          r_valid[w_free_idx] <= 1'b1;
          r_key[w_free_idx]   <= r_ptr;
          r_age[w_free_idx]   <= '0;
        end else begin
          r_owned[r_key[w_old_idx]]   <= 1'b0;
          r_blocked[r_key[w_old_idx]] <= 1'b1;
          r_owned[r_ptr]              <= 1'b1;
          r_key[w_old_idx]            <= r_ptr;
          r_age[w_old_idx]            <= '0;
        end
      end else if (w_release) begin
        r_owned[r_ptr]     <= 1'b0;
        r_valid[w_rel_idx] <= 1'b0;
        r_key[w_rel_idx]   <= '0;
        r_age[w_rel_idx]   <= '0;
      end
    end
  end

  always_comb begin
    key_mask = '0;
    for (int k = 0; k < NKEYS; k++) begin
      for (int v = 0; v < NVOICE; v++) begin
        if (r_valid[v] && (r_key[v] == 6'(k))) begin
          key_mask[k] = 1'b1;
        end
      end
    end
  end

  generate
    for (genvar v = 0; v < NVOICE; v++) begin : g_voice_out
      assign voice_key[6*v +: 6] = r_key[v];
    end
  endgenerate

  assign voice_valid = r_valid;
  assign scan_done   = r_scan_done;

endmodule
`default_nettype wire
